// File: rtl/stacker_ctrl_pkg.sv
// stacker_ctrl_pkg: state/direction encodings and default geometry for the stacker sequencer
package stacker_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SLIDE = 3'd2,
    LOCK  = 3'd3,
    DONE  = 3'd4
  } state_t;
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;
  localparam int ROWS_DEF     = 8;
  localparam int COLS_DEF     = 8;
  localparam int INIT_LEN_DEF = 3;
endpackage

// File: rtl/stacker_ctrl_if.sv
// stacker_ctrl_if: row-wide write port from the sequencer into the block array
interface stacker_ctrl_if #(
  parameter int ROW_W = 3,
  parameter int COLS  = 8
);
  logic             wr_strobe;
  logic [ROW_W-1:0] wr_row;
  logic [COLS-1:0]  wr_data;
  modport master(output wr_strobe, wr_row, wr_data);
  modport slave(input wr_strobe, wr_row, wr_data);
endinterface

// File: rtl/stacker_seg_shift.sv
// stacker_seg_shift: one movement step of the sliding segment; bounces at the edges,
// or rotates circularly when STACKER_WRAP_EN is defined.
module stacker_seg_shift
  import stacker_ctrl_pkg::*;
#(
  parameter int COLS = COLS_DEF
) (
  input  logic [COLS-1:0] seg,
  input  dir_t            dir,
  output logic [COLS-1:0] seg_next,
  output dir_t            dir_next
);
`ifdef STACKER_WRAP_EN
  assign dir_next = dir;
  assign seg_next = dir == DIR_LEFT ? {seg[COLS-2:0], seg[COLS-1]} : {seg[0], seg[COLS-1:1]};
`else
  logic at_edge;
  assign at_edge  = dir == DIR_LEFT ? seg[COLS-1] : seg[0];
  assign dir_next = at_edge ? (dir == DIR_LEFT ? DIR_RIGHT : DIR_LEFT) : dir;
  assign seg_next = dir_next == DIR_LEFT ? seg << 1 : seg >> 1;
`endif
endmodule

// File: rtl/stacker_ctrl.sv
// stacker_ctrl: stacker game sequencer owning the block-array write port.
// Define STACKER_WRAP_EN to make the segment rotate instead of bounce.
module stacker_ctrl
  import stacker_ctrl_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int INIT_LEN = INIT_LEN_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           tick,
  input  logic           btn_scen,
  stacker_ctrl_if.master wr,
  output logic [3:0]     level,
  output logic           game_over,
  output logic           win,
  output logic [2:0]     state_o
);
  localparam int RW = $clog2(ROWS);
  state_t          state, state_n;
  dir_t            dir, dir_n, shift_dir;
  logic [COLS-1:0] seg, seg_n, prev, prev_n, shift_seg, lock_v, data_q, data_n;
  logic [RW-1:0]   cur_row, row_n, cnt, cnt_n, wrow_q, wrow_n;
  logic [3:0]      level_n, level_inc;
  logic            win_n, stb_q, stb_n;
  stacker_seg_shift #(.COLS(COLS)) u_shift (
    .seg(seg), .dir(dir), .seg_next(shift_seg), .dir_next(shift_dir)
  );
  assign lock_v       = seg & prev;
  assign level_inc    = level == 4'(ROWS) ? level : level + 4'd1;
  assign wr.wr_strobe = stb_q;
  assign wr.wr_row    = wrow_q;
  assign wr.wr_data   = data_q;
  assign game_over    = state == DONE;
  assign state_o      = state;
  always_comb begin
    state_n = state;
    seg_n   = seg;
    prev_n  = prev;
    row_n   = cur_row;
    dir_n   = dir;
    cnt_n   = cnt;
    level_n = level;
    win_n   = win;
    stb_n   = 1'b0;
    wrow_n  = wrow_q;
    data_n  = data_q;
    if (state != IDLE && !start) state_n = IDLE;
    else begin
      case (state)
        IDLE: if (start) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
        CLEAR: begin
          stb_n  = 1'b1;
          wrow_n = cnt;
          data_n = '0;
          cnt_n  = cnt + 1'b1;
          if (cnt == RW'(ROWS - 1)) begin
            seg_n   = COLS'((1 << INIT_LEN) - 1);
            dir_n   = DIR_LEFT;
            row_n   = '0;
            prev_n  = '1;
            level_n = '0;
            win_n   = 1'b0;
            state_n = SLIDE;
          end
        end
        // button beats a coincident tick: the tick is simply dropped
        SLIDE: if (btn_scen) state_n = LOCK;
        else if (tick) begin
          seg_n  = shift_seg;
          dir_n  = shift_dir;
          stb_n  = 1'b1;
          wrow_n = cur_row;
          data_n = shift_seg;
        end
        LOCK: begin
          stb_n  = 1'b1;
          wrow_n = cur_row;
          data_n = lock_v;
          if (lock_v == '0) state_n = DONE;
          else begin
            level_n = level_inc;
            if (cur_row == RW'(ROWS - 1)) begin
              win_n   = 1'b1;
              state_n = DONE;
            end else begin
              prev_n  = lock_v;
              seg_n   = lock_v;
              row_n   = cur_row + 1'b1;
              state_n = SLIDE;
            end
          end
        end
        DONE: state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      seg     <= '0;
      prev    <= '0;
      cur_row <= '0;
      dir     <= DIR_LEFT;
      cnt     <= '0;
      level   <= '0;
      win     <= 1'b0;
      stb_q   <= 1'b0;
      wrow_q  <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_n;
      seg     <= seg_n;
      prev    <= prev_n;
      cur_row <= row_n;
      dir     <= dir_n;
      cnt     <= cnt_n;
      level   <= level_n;
      win     <= win_n;
      stb_q   <= stb_n;
      wrow_q  <= wrow_n;
      data_q  <= data_n;
    end
  end
endmodule
